// File: rtl/vectored_int.sv
// -----------------------------------------------------------------------------
// vectored_int
//
// Vectored interrupt address generator for the single-cycle MIPS datapath.
// Four device completion lines are latched into a pending register and
// resolved by fixed priority (done1 highest, done4 lowest). While the
// controller acknowledges, the block drives the ROM address of the winning
// source's jump-to-ISR slot. The datapath's intmux loads that address into
// the PC.
//
// Optional feature macro: VECTORED_INT_MASK_EN
//   When defined, a 4-bit enable mask is added. It resets to all-enabled and
//   is written through mask_we/mask_din. A masked source still latches into
//   pending and becomes visible once it is unmasked.
//
// Parameters:
//   VEC_BASE    byte address of done1's vector slot (imem word 124)
//   VEC_STRIDE  byte spacing between consecutive vector slots
//
// Ports:
//   clk       in   1   system clock, rising edge
//   reset     in   1   asynchronous, active-high; clears all state
//   int_ack   in   1   acknowledge; the PC takes int_addr this cycle
//   done1..4  in   1   device completion requests (done1 has highest priority)
//   int_addr  out  32  vector address of the selected source (0 when no ack)
//   irq       out  1   at least one request is active
//   int_src   out  2   index of the winning source (0=done1 .. 3=done4)
//   mask_we   in   1   mask write enable        (VECTORED_INT_MASK_EN only)
//   mask_din  in   4   new mask value           (VECTORED_INT_MASK_EN only)
//   mask      out  4   current mask             (VECTORED_INT_MASK_EN only)
//
// Handshake: there is no valid/ready pair. A request is consumed on the rising
// edge where int_ack=1, irq=1 and int_src selects it. Exactly one source is
// consumed per acknowledge.
// -----------------------------------------------------------------------------
module vectored_int #(
    parameter logic [31:0] VEC_BASE   = 32'h0000_01F0,
    parameter logic [31:0] VEC_STRIDE = 32'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        int_ack,
    input  logic        done1,
    input  logic        done2,
    input  logic        done3,
    input  logic        done4,
`ifdef VECTORED_INT_MASK_EN
    input  logic        mask_we,
    input  logic [3:0]  mask_din,
    output logic [3:0]  mask,
`endif
    output logic [31:0] int_addr,
    output logic        irq,
    output logic [1:0]  int_src
);

    logic [3:0] r_pending;
    logic [3:0] w_done;
    logic [3:0] w_enable;
    logic [3:0] w_active;
    logic [3:0] w_clear;
    logic [1:0] w_src;
    logic       w_any;

    assign w_done = {done4, done3, done2, done1};

`ifdef VECTORED_INT_MASK_EN
    logic [3:0] r_mask;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mask <= 4'b1111;
        end else if (mask_we) begin
            r_mask <= mask_din;
        end
    end

    assign w_enable = r_mask;
    assign mask     = r_mask;
`else
    assign w_enable = 4'b1111;
`endif

    // Raw done lines count in the same cycle they rise. The pending register
    // only holds a request after its line has dropped.
    assign w_active = (w_done | r_pending) & w_enable;
    assign w_any    = |w_active;

    // Fixed priority: the lowest active index wins. It defaults to 0 when idle.
    always_comb begin
        w_src = 2'd0;
        if (w_active[0]) begin
            w_src = 2'd0;
        end else if (w_active[1]) begin
            w_src = 2'd1;
        end else if (w_active[2]) begin
            w_src = 2'd2;
        end else if (w_active[3]) begin
            w_src = 2'd3;
        end
    end

    // The clear is qualified by w_any. Without that, an idle ack (int_src=0)
    // would wipe a masked pending bit 0.
    always_comb begin
        w_clear = 4'b0000;
        if (int_ack && w_any) begin
            w_clear[w_src] = 1'b1;
        end
    end

    // Clear beats set for the selected bit. If the line is still high, the bit
    // re-sets on the following edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending <= 4'b0000;
        end else begin
            r_pending <= (r_pending | w_done) & ~w_clear;
        end
    end

    // Outputs are forced low while reset is high. Raw done lines would
    // otherwise leak through the combinational path.
    assign irq     = w_any & ~reset;
    assign int_src = reset ? 2'd0 : w_src;

    always_comb begin
        int_addr = 32'h0;
        if (!reset && int_ack) begin
            if (w_any) begin
                int_addr = VEC_BASE + (VEC_STRIDE * {30'd0, w_src});
            end else begin
                int_addr = VEC_BASE;
            end
        end
    end

endmodule

// File: tb/tb_vectored_int.sv
// -----------------------------------------------------------------------------
// tb_vectored_int
//
// Directed bench for vectored_int. A table of {inputs, expected outputs}
// records is applied one per clock and checked before the following rising
// edge. The table is order-dependent because pending state carries between
// rows. Hand-written sequences cover the asynchronous reset and, when
// VECTORED_INT_MASK_EN is defined, the mask register.
// -----------------------------------------------------------------------------
module tb_vectored_int;

    logic        clk;
    logic        reset;
    logic        int_ack;
    logic        done1, done2, done3, done4;
    logic [31:0] int_addr;
    logic        irq;
    logic [1:0]  int_src;
`ifdef VECTORED_INT_MASK_EN
    logic        mask_we;
    logic [3:0]  mask_din;
    logic [3:0]  mask;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    logic [31:0] exp_q[$];

    typedef struct {
        logic        rst;
        logic        ack;
        logic [3:0]  done;      // bit0 = done1
        logic        exp_irq;
        logic [1:0]  exp_src;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs[$];

    vectored_int dut (
        .clk      (clk),
        .reset    (reset),
        .int_ack  (int_ack),
        .done1    (done1),
        .done2    (done2),
        .done3    (done3),
        .done4    (done4),
`ifdef VECTORED_INT_MASK_EN
        .mask_we  (mask_we),
        .mask_din (mask_din),
        .mask     (mask),
`endif
        .int_addr (int_addr),
        .irq      (irq),
        .int_src  (int_src)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic drive(input logic rst, input logic ack, input logic [3:0] d);
        reset   = rst;
        int_ack = ack;
        done1   = d[0];
        done2   = d[1];
        done3   = d[2];
        done4   = d[3];
    endtask

    task automatic add(input logic rst, input logic ack, input logic [3:0] d,
                       input logic e_irq, input logic [1:0] e_src,
                       input logic [31:0] e_addr);
        vec_t v;
        v.rst = rst; v.ack = ack; v.done = d;
        v.exp_irq = e_irq; v.exp_src = e_src; v.exp_addr = e_addr;
        vecs.push_back(v);
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic e_irq,
                                 input logic [1:0] e_src, input logic [31:0] e_addr);
        exp_q.push_back(e_addr);
        check({tag, ".irq"}, {31'd0, irq}, {31'd0, e_irq});
        check({tag, ".int_src"}, {30'd0, int_src}, {30'd0, e_src});
        check({tag, ".int_addr"}, int_addr, exp_q.pop_front());
    endtask

    initial begin
        drive(1'b1, 1'b0, 4'b0000);
`ifdef VECTORED_INT_MASK_EN
        mask_we  = 1'b0;
        mask_din = 4'b0000;
`endif

        //   rst ack done      irq src addr
        // reset held with everything asserted, then release
        add(1, 1, 4'b1111,   0, 0, 32'h0);
        add(0, 1, 4'b1111,   1, 0, 32'h1F0);
        add(0, 0, 4'b0000,   1, 1, 32'h0);      // bits 1..3 still pending
        add(1, 0, 4'b0000,   0, 0, 32'h0);
        // one-cycle pulse on done3
        add(0, 0, 4'b0100,   1, 2, 32'h0);
        add(0, 0, 4'b0000,   1, 2, 32'h0);
        add(0, 1, 4'b0000,   1, 2, 32'h1F8);
        add(0, 0, 4'b0000,   0, 0, 32'h0);
        add(0, 1, 4'b0000,   0, 0, 32'h1F0);    // idle ack -> VEC_BASE
        // done2 + done4 together
        add(0, 0, 4'b1010,   1, 1, 32'h0);
        add(0, 1, 4'b0000,   1, 1, 32'h1F4);
        add(0, 1, 4'b0000,   1, 3, 32'h1FC);
        add(0, 0, 4'b0000,   0, 0, 32'h0);
        // done1 level held with ack: re-sets every edge
        add(0, 1, 4'b0001,   1, 0, 32'h1F0);
        add(0, 1, 4'b0001,   1, 0, 32'h1F0);
        add(0, 1, 4'b0001,   1, 0, 32'h1F0);
        add(0, 0, 4'b0000,   0, 0, 32'h0);
        // only one source cleared per ack
        add(0, 1, 4'b0011,   1, 0, 32'h1F0);
        add(0, 0, 4'b0000,   1, 1, 32'h0);
        add(0, 1, 4'b0000,   1, 1, 32'h1F4);
        add(0, 0, 4'b0000,   0, 0, 32'h0);
        // done3 + done4
        add(0, 0, 4'b1100,   1, 2, 32'h0);
        add(0, 1, 4'b0000,   1, 2, 32'h1F8);
        add(0, 1, 4'b0000,   1, 3, 32'h1FC);
        add(0, 0, 4'b0000,   0, 0, 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].ack, vecs[i].done);
            #2;
            check_outputs($sformatf("vec%0d", i), vecs[i].exp_irq,
                          vecs[i].exp_src, vecs[i].exp_addr);
        end

        // ---- asynchronous reset between edges ----
        @(negedge clk);
        drive(1'b0, 1'b0, 4'b1000);
        @(negedge clk);
        drive(1'b0, 1'b0, 4'b0000);
        #1;
        check_outputs("async.pend", 1'b1, 2'd3, 32'h0);
        reset   = 1'b1;
        int_ack = 1'b1;
        #1;
        check_outputs("async.held", 1'b0, 2'd0, 32'h0);
        reset   = 1'b0;
        int_ack = 1'b0;
        #1;
        check_outputs("async.rel", 1'b0, 2'd0, 32'h0);
        @(negedge clk);
        #1;
        check_outputs("async.after", 1'b0, 2'd0, 32'h0);

`ifdef VECTORED_INT_MASK_EN
        // ---- mask register ----
        @(negedge clk);
        drive(1'b1, 1'b0, 4'b0000);
        #1;
        check("mask.reset", {28'd0, mask}, 32'hF);
        @(negedge clk);
        drive(1'b0, 1'b0, 4'b0000);
        mask_we = 1'b1; mask_din = 4'b1110;
        @(negedge clk);
        mask_we = 1'b0;
        check("mask.write", {28'd0, mask}, 32'hE);
        drive(1'b0, 1'b0, 4'b0011);
        #1;
        check_outputs("mask.pend", 1'b1, 2'd1, 32'h0);
        @(negedge clk);
        drive(1'b0, 1'b1, 4'b0000);
        #1;
        check_outputs("mask.ack1", 1'b1, 2'd1, 32'h1F4);
        @(negedge clk);
        drive(1'b0, 1'b0, 4'b0000);
        #1;
        check_outputs("mask.hidden", 1'b0, 2'd0, 32'h0);
        mask_we = 1'b1; mask_din = 4'b1111;
        @(negedge clk);
        mask_we = 1'b0;
        drive(1'b0, 1'b1, 4'b0000);
        #1;
        check_outputs("mask.ack0", 1'b1, 2'd0, 32'h1F0);
        @(negedge clk);
        drive(1'b0, 1'b0, 4'b0000);
        #1;
        check_outputs("mask.empty", 1'b0, 2'd0, 32'h0);
`endif

        // ---- final report ----
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
